// File: rtl/sn74169_ctrl_pkg.sv
// Shared types and helpers for the sn74169 counter-chain sequencer.
package sn74169_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_START  = 2'b00,
        OP_PAUSE  = 2'b01,
        OP_RESUME = 2'b10,
        OP_ABORT  = 2'b11
    } cmd_op_t;

    // A nibble is terminal when it is about to carry (up) or borrow (down).
    function automatic logic nibble_is_term(input logic [3:0] nib, input logic up);
        return up ? (nib == 4'hF) : (nib == 4'h0);
    endfunction

endpackage

// File: rtl/sn74169_entb_gen.sv
// Per-stage carry-enable generation for a chain of 4-bit up/down counters.
// Stage k may count only when every lower nibble sits at its terminal value.
// Also flags the penultimate chain value, where the next step lands on terminal.
module sn74169_entb_gen
    import sn74169_ctrl_pkg::*;
#(
    parameter int NSTAGE = 2
) (
    input  logic                  i_run,
    input  logic                  i_up,
    input  logic [4*NSTAGE-1:0]   i_q,
    output logic [NSTAGE-1:0]     o_entb,
    output logic                  o_pen_hit
);

    logic [NSTAGE-1:0] w_nib_term;
    logic              w_nib0_pen;

    // Nibble 0 sits one step short of terminal: E when counting up, 1 when down.
    assign w_nib0_pen = i_up ? (i_q[3:0] == 4'hE) : (i_q[3:0] == 4'h1);

    genvar k;
    generate
        for (k = 0; k < NSTAGE; k++) begin : g_stage
            assign w_nib_term[k] = nibble_is_term(i_q[4*k +: 4], i_up);
            if (k == 0) begin : g_first
                assign o_entb[k] = ~i_run;
            end else begin : g_upper
                assign o_entb[k] = ~(i_run & (&w_nib_term[k-1:0]));
            end
        end

        if (NSTAGE == 1) begin : g_pen_single
            assign o_pen_hit = w_nib0_pen & (w_nib_term[0] | ~w_nib_term[0]);
        end else begin : g_pen_multi
            assign o_pen_hit = w_nib0_pen & (&w_nib_term[NSTAGE-1:1]);
        end
    endgenerate

endmodule

// File: rtl/sn74169_seq_ctrl.sv
// Programmable interval timer sequencer driving a chain of sn74169 counters.
// Handles START/PAUSE/RESUME/ABORT, one-shot or auto-reload, and counts periods.
module sn74169_seq_ctrl
    import sn74169_ctrl_pkg::*;
#(
    parameter int NSTAGE = 2,
    parameter int PCW    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstb,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [4*NSTAGE-1:0]   i_cmd_preset,
    input  logic                  i_cmd_dir,
    input  logic                  i_cmd_auto,
    input  logic [4*NSTAGE-1:0]   i_q,
    output logic [4*NSTAGE-1:0]   o_a,
    output logic                  o_loadb,
    output logic                  o_u_db,
    output logic                  o_enpb,
    output logic [NSTAGE-1:0]     o_entb,
    output logic                  o_busy,
    output logic                  o_tc_pulse,
    output logic                  o_illegal,
    output logic [PCW-1:0]        o_periods
);

    localparam int W = 4 * NSTAGE;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic            r_loadb;
    logic            r_udb;
    logic            r_enpb;
    logic            r_auto;
    logic            r_tc;
    logic            r_ill;
    logic [PCW-1:0]  r_periods;

    logic            w_accept;
    logic            w_run;
    logic            w_pen_hit;
    logic            w_load_term;

    assign o_cmd_ready = (r_state != ST_LOAD);
    assign o_busy      = (r_state != ST_IDLE);
    assign w_accept    = i_cmd_valid & o_cmd_ready;
    assign w_run       = (r_state == ST_RUN);
    // The direction register doubles as the latched START direction.
    assign w_load_term = r_udb ? (&r_a) : ~(|r_a);

    assign o_a        = r_a;
    assign o_loadb    = r_loadb;
    assign o_u_db     = r_udb;
    assign o_enpb     = r_enpb;
    assign o_tc_pulse = r_tc;
    assign o_illegal  = r_ill;
    assign o_periods  = r_periods;

    sn74169_entb_gen #(
        .NSTAGE    (NSTAGE)
    ) u_entb_gen (
        .i_run     (w_run),
        .i_up      (r_udb),
        .i_q       (i_q),
        .o_entb    (o_entb),
        .o_pen_hit (w_pen_hit)
    );

    // Sequencer FSM: terminal-count handling first, accepted commands override it.
    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_loadb   <= 1'b1;
            r_udb     <= 1'b1;
            r_enpb    <= 1'b1;
            r_auto    <= 1'b0;
            r_tc      <= 1'b0;
            r_ill     <= 1'b0;
            r_periods <= '0;
        end else begin
            r_tc  <= 1'b0;
            r_ill <= 1'b0;

            case (r_state)
                ST_LOAD: begin
                    if (w_load_term) begin
                        r_tc      <= 1'b1;
                        r_periods <= r_periods + PCW'(1);
                        if (r_auto) begin
                            r_loadb <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_loadb <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_RUN;
                        r_loadb <= 1'b1;
                        r_enpb  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_pen_hit) begin
                        r_tc      <= 1'b1;
                        r_periods <= r_periods + PCW'(1);
                        r_enpb    <= 1'b1;
                        if (r_auto) begin
                            r_state <= ST_LOAD;
                            r_loadb <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (w_accept) begin
                case (cmd_op_t'(i_cmd_op))
                    OP_START: begin
                        r_state   <= ST_LOAD;
                        r_a       <= i_cmd_preset;
                        r_udb     <= i_cmd_dir;
                        r_auto    <= i_cmd_auto;
                        r_loadb   <= 1'b0;
                        r_enpb    <= 1'b1;
                        r_periods <= '0;
                    end
                    OP_PAUSE: begin
                        if (w_run && !w_pen_hit) begin
                            r_state <= ST_PAUSE;
                            r_enpb  <= 1'b1;
                        end else begin
                            r_ill <= 1'b1;
                        end
                    end
                    OP_RESUME: begin
                        if (r_state == ST_PAUSE) begin
                            r_state <= ST_RUN;
                            r_enpb  <= 1'b0;
                        end else begin
                            r_ill <= 1'b1;
                        end
                    end
                    OP_ABORT: begin
                        if (r_state != ST_IDLE) begin
                            r_state <= ST_IDLE;
                            r_loadb <= 1'b1;
                            r_enpb  <= 1'b1;
                        end else begin
                            r_ill <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
